// File: rtl/sr_excitation_driver_if.sv
// Target-bit handshake bundle for sr_excitation_driver.
interface sr_excitation_driver_if;
  logic in_valid;
  logic in_bit;
  logic in_ready;

  modport master (output in_valid, output in_bit, input in_ready);
  modport slave  (input in_valid, input in_bit, output in_ready);
endinterface

// File: rtl/sr_excitation_driver.sv
// Turns a FIFO of target Q bits into S/R pulses for an SR flop and checks the readback.
// Macro SR_DRV_CHECK_EN enables readback checking (mismatch, err_cnt, qm <- Q resync).
module sr_excitation_driver #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sr_excitation_driver_if.slave in_if,
  output logic                 S,
  output logic                 R,
  input  logic                 Q,
  output logic                 busy,
  output logic                 mismatch,
  output logic [CNT_W-1:0]     drv_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             t_q, t_d;
  logic             qm_q, qm_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic [CNT_W-1:0] drv_cnt_q, drv_cnt_d;

  logic full, empty, push, pop, head, qm_eff;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_if.in_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  assign in_if.in_ready = !full;
  assign S       = s_q;
  assign R       = r_q;
  assign drv_cnt = drv_cnt_q;
  assign busy    = (state_q != IDLE) || !empty;

`ifdef SR_DRV_CHECK_EN
  logic             chk_fail;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign mismatch = mismatch_q;
  assign err_cnt  = err_cnt_q;
`else
  logic unused_q;

  assign unused_q = Q;
  assign mismatch = 1'b0;
  assign err_cnt  = '0;
`endif

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_if.in_bit;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // In CHECK the excitation for a back-to-back pop uses the freshly resynced qm.
  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    qm_d      = qm_q;
    s_d       = 1'b0;
    r_d       = 1'b0;
    drv_cnt_d = drv_cnt_q;
    pop       = 1'b0;
    qm_eff    = qm_q;
`ifdef SR_DRV_CHECK_EN
    chk_fail  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        state_d = CHECK;
      end
      CHECK: begin
        drv_cnt_d = drv_cnt_q + CNT_W'(1);
`ifdef SR_DRV_CHECK_EN
        qm_eff    = Q;
        chk_fail  = (Q != t_q);
`else
        qm_eff    = t_q;
`endif
        qm_d = qm_eff;
        if (!empty) begin
          pop     = 1'b1;
          state_d = DRIVE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (pop) begin
      t_d = head;
      s_d = head & ~qm_eff;
      r_d = ~head & qm_eff;
    end
  end

`ifdef SR_DRV_CHECK_EN
  always_comb begin
    mismatch_d = chk_fail;
    err_cnt_d  = err_cnt_q;
    if (chk_fail && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      t_q       <= 1'b0;
      qm_q      <= 1'b0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      drv_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      t_q       <= t_d;
      qm_q      <= qm_d;
      s_q       <= s_d;
      r_q       <= r_d;
      drv_cnt_q <= drv_cnt_d;
    end
  end

endmodule

// File: tb/tb_sr_excitation_driver.sv
// Directed bench for sr_excitation_driver driving a modelled SR flop.
module tb_sr_excitation_driver;

`ifdef SR_DRV_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_excitation_driver_if in_if ();
  sr_excitation_driver_if in_if2 ();

  logic       s, r, q, busy, mm;
  logic [7:0] drv, err;
  logic       s2, r2, q2, busy2, mm2;
  logic [1:0] drv2, err2;

  assign q2 = 1'b0;

  sr_excitation_driver #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_if(in_if),
    .S(s), .R(r), .Q(q), .busy(busy), .mismatch(mm),
    .drv_cnt(drv), .err_cnt(err)
  );

  sr_excitation_driver #(.DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_if(in_if2),
    .S(s2), .R(r2), .Q(q2), .busy(busy2), .mismatch(mm2),
    .drv_cnt(drv2), .err_cnt(err2)
  );

  // SR flop model: S sets, R clears; q_stuck forces the captured value to 0.
  logic q_ff;
  logic q_stuck = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) q_ff <= 1'b0;
    else     q_ff <= q_stuck ? 1'b0 : (s | (q_ff & ~r));
  end
  assign q = q_ff;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int         cyc, s_cnt, r_cnt, mm_cnt, mm_at, both_cnt;
  logic [1:0] cmds[$];
  logic       pbits[$];

  task automatic clear_obs();
    cyc = 0; s_cnt = 0; r_cnt = 0; mm_cnt = 0; mm_at = -1; both_cnt = 0;
    cmds.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (s && r) both_cnt++;
    if (s) begin s_cnt++; cmds.push_back(2'b10); end
    if (r) begin r_cnt++; cmds.push_back(2'b01); end
    if (mm) begin mm_cnt++; mm_at = cyc; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_if.in_valid  = 1'b0;
    in_if2.in_valid = 1'b0;
    q_stuck = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_bits(output int first_stall);
    int  idx;
    int  guard;
    logic acc;
    idx = 0; guard = 0; first_stall = -1;
    while (idx < pbits.size() && guard < 200) begin
      in_if.in_valid = 1'b1;
      in_if.in_bit   = pbits[idx];
      acc = in_if.in_ready;
      if (!acc && first_stall < 0) first_stall = idx;
      tick();
      if (acc) idx++;
      guard++;
    end
    in_if.in_valid = 1'b0;
    check("push_all_accepted", idx, pbits.size());
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (busy && guard < 100) begin
      tick();
      guard++;
    end
    check(name, busy, 0);
  endtask

  typedef struct {
    logic        vld;
    logic        tgt;
    logic        s;
    logic        r;
    logic        busy;
    logic        rdy;
    int unsigned drv;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         fs;
    logic       qm;
    logic [1:0] exp_cmds[$];

    // Back-to-back 1,1,0,0,1 from reset: {vld, tgt, S, R, busy, in_ready, drv_cnt} after each edge.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5};

    in_if.in_valid  = 1'b0;
    in_if.in_bit    = 1'b0;
    in_if2.in_valid = 1'b0;
    in_if2.in_bit   = 1'b0;
    clear_obs();

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_S", s, 0);
    check("rst_R", r, 0);
    check("rst_mismatch", mm, 0);
    check("rst_busy", busy, 0);
    check("rst_drv_cnt", drv, 0);
    check("rst_err_cnt", err, 0);
    check("rst_in_ready", in_if.in_ready, 1);
    check("rst_in_ready2", in_if2.in_ready, 1);
    rst = 1'b0;

    clear_obs();
    for (int i = 0; i < 13; i++) begin
      in_if.in_valid = vecs[i].vld;
      in_if.in_bit   = vecs[i].tgt;
      tick();
      check($sformatf("seq[%0d].S", i), s, vecs[i].s);
      check($sformatf("seq[%0d].R", i), r, vecs[i].r);
      check($sformatf("seq[%0d].busy", i), busy, vecs[i].busy);
      check($sformatf("seq[%0d].in_ready", i), in_if.in_ready, vecs[i].rdy);
      check($sformatf("seq[%0d].drv_cnt", i), drv, vecs[i].drv);
    end
    in_if.in_valid = 1'b0;
    check("seq_mismatch_pulses", mm_cnt, 0);
    check("seq_sr_both_high", both_cnt, 0);
    check("seq_final_q", q, 1);

    // Single set
    do_reset();
    clear_obs();
    pbits = {1'b1};
    push_bits(fs);
    repeat (6) tick();
    check("single_S_cycles", s_cnt, 1);
    check("single_R_cycles", r_cnt, 0);
    check("single_q", q, 1);
    check("single_drv_cnt", drv, 1);
    check("single_mismatch_pulses", mm_cnt, 0);
    check("single_busy", busy, 0);

    // Backpressure and ordering
    do_reset();
    clear_obs();
    pbits = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    push_bits(fs);
    check("bp_first_stall_after", fs, 7);
    wait_idle("bp_drain_busy");
    check("bp_drv_cnt", drv, 10);
    check("bp_mismatch_pulses", mm_cnt, 0);
    check("bp_sr_both_high", both_cnt, 0);
    check("bp_final_q", q, 0);
    qm = 1'b0;
    exp_cmds.delete();
    foreach (pbits[i]) begin
      if (pbits[i] && !qm) exp_cmds.push_back(2'b10);
      if (!pbits[i] && qm) exp_cmds.push_back(2'b01);
      qm = pbits[i];
    end
    check("bp_cmd_count", cmds.size(), exp_cmds.size());
    for (int i = 0; i < exp_cmds.size() && i < cmds.size(); i++) begin
      check($sformatf("bp_cmd[%0d]", i), cmds[i], exp_cmds[i]);
    end

    // Mismatch: flop stuck at 0 while target is 1
    do_reset();
    clear_obs();
    q_stuck = 1'b1;
    pbits = {1'b1};
    push_bits(fs);
    repeat (5) tick();
    check("mm_S_cycles", s_cnt, 1);
    check("mm_pulses", mm_cnt, CHK_EN ? 1 : 0);
    check("mm_pulse_cycle", mm_at, CHK_EN ? 4 : -1);
    check("mm_err_cnt", err, CHK_EN ? 1 : 0);
    q_stuck = 1'b0;
    clear_obs();
    push_bits(fs);
    repeat (5) tick();
    check("mm_next_S_cycles", s_cnt, CHK_EN ? 1 : 0);
    check("mm_next_q", q, CHK_EN ? 1 : 0);
    check("mm_next_pulses", mm_cnt, 0);
    check("mm_next_err_cnt", err, CHK_EN ? 1 : 0);
    check("mm_next_drv_cnt", drv, 2);

    // Reset during DRIVE with S=1 and a target still queued
    do_reset();
    clear_obs();
    pbits = {1'b1, 1'b0, 1'b1, 1'b1};
    push_bits(fs);
    tick();
    tick();
    check("rmid_pre_S", s, 1);
    check("rmid_pre_drv_cnt", drv, 2);
    check("rmid_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("rmid_S", s, 0);
    check("rmid_R", r, 0);
    check("rmid_busy", busy, 0);
    check("rmid_drv_cnt", drv, 0);
    check("rmid_err_cnt", err, 0);
    check("rmid_mismatch", mm, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rmid_in_ready", in_if.in_ready, 1);
    repeat (4) tick();
    check("rmid_fifo_discarded_busy", busy, 0);
    check("rmid_after_drv_cnt", drv, 0);
    clear_obs();
    pbits = {1'b1};
    push_bits(fs);
    repeat (6) tick();
    check("rmid_single_S_cycles", s_cnt, 1);
    check("rmid_single_R_cycles", r_cnt, 0);
    check("rmid_single_q", q, 1);
    check("rmid_single_drv_cnt", drv, 1);
    check("rmid_single_mismatch", mm_cnt, 0);

    // err_cnt saturation on the CNT_W=2 instance with Q tied low
    begin
      int acc_n;
      int guard;
      logic acc;
      acc_n = 0; guard = 0;
      while (acc_n < 5 && guard < 100) begin
        in_if2.in_valid = 1'b1;
        in_if2.in_bit   = 1'b1;
        acc = in_if2.in_ready;
        tick();
        if (acc) acc_n++;
        guard++;
      end
      in_if2.in_valid = 1'b0;
      check("sat_accepted", acc_n, 5);
      guard = 0;
      while (busy2 && guard < 100) begin
        tick();
        guard++;
      end
      check("sat_busy", busy2, 0);
      check("sat_err_cnt", err2, CHK_EN ? 3 : 0);
      check("sat_drv_cnt_wrap", drv2, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
